// File: rtl/size_conv_pkg.sv
// Shared types and constants for the word-to-byte scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package size_conv_pkg;

  // Scheduler holds either nothing or one word being serialised.
  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } stateT;

  // Filler symbol driven on the byte stream when no word is in flight.
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

  // Bytes per word in each width mode.
  localparam int NB16 = 2;
  localparam int NB32 = 4;

  // Index of the final byte of a word loaded with the given MODE.
  function automatic logic [1:0] lastByteIdx(input logic mode);
    return mode ? 2'(NB32 - 1) : 2'(NB16 - 1);
  endfunction

endpackage

// File: rtl/size_convert_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
// Latency: winner is combinational; pointer updates on the accepting edge.
// Backpressure: pointer only moves on an accepted word, so a dropped request costs nothing.
module rr_arb2
  import size_conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       loadEn,
  input  logic       accept,
  output logic       winner,
  output logic       pointer
);

  // Pick the sole requester, or on a tie the one that did not win last time.
  always_comb begin
    winner = ~pointer;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~pointer;
      default: winner = ~pointer;
    endcase
  end

  // Remember the last granted requester; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer <= 1'b1;
    end else if (loadEn && accept) begin
      pointer <= winner;
    end
  end

endmodule

// File: rtl/size_convert_sched.sv
// Shares one word-to-byte converter between two requesters, LSB byte first.
// Latency: byte 0 appears on DATA_OUT one edge after the handshake, then one byte per edge.
// Backpressure: READY only on the last byte (or when empty), so words go out back to back.
module size_convert_sched
  import size_conv_pkg::*;
#(
  parameter int              SIZE     = 8,
  parameter logic [SIZE-1:0] IDLE_SYM = SIZE'(IDLE_SYM_DEF)
) (
  input  logic                BIT_RATE_CLK10,
  input  logic                RESET,
  input  logic                MODE,
  input  logic                REQ0_VALID,
  input  logic [4*SIZE-1:0]   REQ0_DATA,
  output logic                REQ0_READY,
  input  logic                REQ1_VALID,
  input  logic [4*SIZE-1:0]   REQ1_DATA,
  output logic                REQ1_READY,
  output logic [SIZE-1:0]     DATA_OUT,
  output logic                VALID_OUT,
  output logic                IDLE_BUFFER,
  output logic                GRANT,
  output logic [1:0]          BYTE_IDX
);

  stateT             stateQ;
  stateT             stateD;
  logic [4*SIZE-1:0] wordQ;
  logic [1:0]        lastIdxQ;
  logic [1:0]        byteIdxD;
  logic [SIZE-1:0]   dataD;
  logic              loadEn;
  logic              winner;
  logic              lastGrantPtr;
  logic              accept;
  logic [4*SIZE-1:0] selWord;

  // A new word may load when nothing is held or the final byte is on the output now.
  assign loadEn = (stateQ == EMPTY) || (BYTE_IDX == lastIdxQ);

  rr_arb2 uArb (
    .clk     (BIT_RATE_CLK10),
    .rst     (RESET),
    .req     ({REQ1_VALID, REQ0_VALID}),
    .loadEn  (loadEn),
    .accept  (accept),
    .winner  (winner),
    .pointer (lastGrantPtr)
  );

  // READY is purely a function of VALID and held state; both forced low during reset.
  assign REQ0_READY = ~RESET & loadEn & ~winner & REQ0_VALID;
  assign REQ1_READY = ~RESET & loadEn &  winner & REQ1_VALID;
  assign accept     = REQ0_READY | REQ1_READY;
  assign selWord    = winner ? REQ1_DATA : REQ0_DATA;

  // Next state, next byte index and next output byte.
  always_comb begin
    stateD   = stateQ;
    byteIdxD = BYTE_IDX;
    dataD    = IDLE_SYM;
    if (accept) begin
      stateD   = SEND;
      byteIdxD = 2'd0;
      dataD    = selWord[SIZE-1:0];
    end else if (loadEn) begin
      stateD   = EMPTY;
      byteIdxD = 2'd0;
      dataD    = IDLE_SYM;
    end else begin
      byteIdxD = BYTE_IDX + 2'd1;
      dataD    = wordQ[int'(byteIdxD)*SIZE +: SIZE];
    end
  end

  // State register.
  always_ff @(posedge BIT_RATE_CLK10 or posedge RESET) begin
    if (RESET) begin
      stateQ <= EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  // Capture the accepted word, its length and owner; MODE is ignored until the next load.
  always_ff @(posedge BIT_RATE_CLK10 or posedge RESET) begin
    if (RESET) begin
      wordQ    <= '0;
      lastIdxQ <= 2'd0;
      GRANT    <= 1'b0;
    end else if (accept) begin
      wordQ    <= selWord;
      lastIdxQ <= lastByteIdx(MODE);
      GRANT    <= winner;
    end
  end

  // Registered byte stream; VALID_OUT and IDLE_BUFFER are kept as complements.
  always_ff @(posedge BIT_RATE_CLK10 or posedge RESET) begin
    if (RESET) begin
      DATA_OUT    <= IDLE_SYM;
      VALID_OUT   <= 1'b0;
      IDLE_BUFFER <= 1'b1;
      BYTE_IDX    <= 2'd0;
    end else begin
      DATA_OUT    <= dataD;
      VALID_OUT   <= (stateD == SEND);
      IDLE_BUFFER <= (stateD != SEND);
      BYTE_IDX    <= byteIdxD;
    end
  end

endmodule

// File: tb/tb_size_convert_sched.sv
// Scoreboarded bench: handshakes push expected bytes, a monitor pops and compares.
// Latency: expects byte 0 one edge after each handshake and no gaps within/between words.
// Backpressure: READY expectation derived from a byte-queue model and last-grant tracker.
module tb_size_convert_sched;

  logic        clk;
  logic        RESET;
  logic        MODE;
  logic        REQ0_VALID;
  logic [31:0] REQ0_DATA;
  logic        REQ0_READY;
  logic        REQ1_VALID;
  logic [31:0] REQ1_DATA;
  logic        REQ1_READY;
  logic [7:0]  DATA_OUT;
  logic        VALID_OUT;
  logic        IDLE_BUFFER;
  logic        GRANT;
  logic [1:0]  BYTE_IDX;

  size_convert_sched #(.SIZE(8), .IDLE_SYM(8'h7C)) dut (
    .BIT_RATE_CLK10 (clk),
    .RESET          (RESET),
    .MODE           (MODE),
    .REQ0_VALID     (REQ0_VALID),
    .REQ0_DATA      (REQ0_DATA),
    .REQ0_READY     (REQ0_READY),
    .REQ1_VALID     (REQ1_VALID),
    .REQ1_DATA      (REQ1_DATA),
    .REQ1_READY     (REQ1_READY),
    .DATA_OUT       (DATA_OUT),
    .VALID_OUT      (VALID_OUT),
    .IDLE_BUFFER    (IDLE_BUFFER),
    .GRANT          (GRANT),
    .BYTE_IDX       (BYTE_IDX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic       gnt;
    logic [1:0] idx;
  } expByteT;

  expByteT expQ[$];
  logic    lastGrant;
  int      nChecked = 0;
  int      nBad     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecked++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the output must be the next queued byte, or idle if none is owed.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        expByteT e;
        e = expQ.pop_front();
        chk("valid_out", VALID_OUT, 1);
        chk("idle_buf", IDLE_BUFFER, 0);
        chk("data_out", DATA_OUT, e.dat);
        chk("grant", GRANT, e.gnt);
        chk("byte_idx", BYTE_IDX, e.idx);
      end else begin
        chk("idle_valid_out", VALID_OUT, 0);
        chk("idle_buf", IDLE_BUFFER, 1);
        chk("idle_data_out", DATA_OUT, 8'h7C);
        chk("idle_byte_idx", BYTE_IDX, 0);
      end
    end
  end

  // Handshake observer: predicts READY and, on an accept, queues the word's bytes.
  initial begin
    forever begin
      logic       canLoad;
      logic       exp0;
      logic       exp1;
      logic [31:0] w;
      int         nb;
      @(negedge clk);
      #1;
      canLoad = (expQ.size() == 0) && !RESET;
      exp0 = canLoad && REQ0_VALID && (!REQ1_VALID || lastGrant == 1'b1);
      exp1 = canLoad && REQ1_VALID && (!REQ0_VALID || lastGrant == 1'b0);
      chk("req0_ready", REQ0_READY, exp0);
      chk("req1_ready", REQ1_READY, exp1);
      if (exp0 || exp1) begin
        w  = exp0 ? REQ0_DATA : REQ1_DATA;
        nb = MODE ? 4 : 2;
        for (int k = 0; k < nb; k++) begin
          expByteT e;
          e.dat = w[k*8 +: 8];
          e.gnt = exp1;
          e.idx = 2'(k);
          expQ.push_back(e);
        end
        lastGrant = exp1;
      end
    end
  end

  // Hold VALID until the handshake is seen, then drop it just after the accepting edge.
  task automatic waitAccept(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      #2;
      if (n == 0) done = REQ0_VALID && REQ0_READY;
      else        done = REQ1_VALID && REQ1_READY;
    end
    if (!done) begin
      nChecked++;
      nBad++;
      $display("FAIL accept_timeout req%0d: no READY within 64 cycles", n);
    end
    @(posedge clk);
    #1;
    if (n == 0) REQ0_VALID = 1'b0;
    else        REQ1_VALID = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic hs0;
    logic hs1;
    lastGrant  = 1'b1;
    RESET      = 1'b1;
    MODE       = 1'b1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    REQ0_DATA  = '0;
    REQ1_DATA  = '0;
    idleCycles(3);
    RESET = 1'b0;
    idleCycles(10);

    // 32-bit word from requester 0.
    MODE = 1'b1;
    REQ0_DATA = 32'hDDCCBBAA;
    REQ0_VALID = 1'b1;
    waitAccept(0);
    idleCycles(6);

    // 16-bit word from requester 1; MODE flipped after load must not lengthen it.
    MODE = 1'b0;
    REQ1_DATA = 32'h1234_5678;
    REQ1_VALID = 1'b1;
    waitAccept(1);
    MODE = 1'b1;
    idleCycles(5);

    // Requester 0 waits while a requester 1 word is in flight.
    MODE = 1'b1;
    REQ1_DATA = 32'hA1B2C3D4;
    REQ1_VALID = 1'b1;
    waitAccept(1);
    REQ0_DATA = 32'h0BADF00D;
    REQ0_VALID = 1'b1;
    waitAccept(0);
    idleCycles(6);

    // Both requesters saturated, 32-bit: grants must alternate with no idle bytes.
    for (int phase = 0; phase < 2; phase++) begin
      int pct;
      pct = (phase == 0) ? 100 : 50;
      for (int c = 0; c < ((phase == 0) ? 40 : 600); c++) begin
        @(negedge clk);
        #2;
        hs0 = REQ0_VALID && REQ0_READY;
        hs1 = REQ1_VALID && REQ1_READY;
        @(posedge clk);
        #1;
        if (hs0 || !REQ0_VALID) begin
          REQ0_VALID = ($urandom_range(99) < pct);
          REQ0_DATA  = $urandom;
        end else if (phase == 1 && $urandom_range(99) < 5) begin
          REQ0_VALID = 1'b0;
        end
        if (hs1 || !REQ1_VALID) begin
          REQ1_VALID = ($urandom_range(99) < pct);
          REQ1_DATA  = $urandom;
        end else if (phase == 1 && $urandom_range(99) < 5) begin
          REQ1_VALID = 1'b0;
        end
        MODE = (phase == 0) ? 1'b1 : 1'($urandom_range(1));
      end
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
      idleCycles(6);
    end

    // Reset in the middle of a 32-bit word, after byte 1 is on the output.
    MODE = 1'b1;
    REQ1_DATA = 32'h5566_7788;
    REQ1_VALID = 1'b1;
    waitAccept(1);
    REQ0_DATA = 32'h4433_2211;
    REQ0_VALID = 1'b1;
    waitAccept(0);
    @(posedge clk);
    #2;
    RESET = 1'b1;
    expQ.delete();
    lastGrant = 1'b1;
    #1;
    chk("rst_async_data", DATA_OUT, 8'h7C);
    chk("rst_async_valid", VALID_OUT, 0);
    chk("rst_async_idle", IDLE_BUFFER, 1);
    chk("rst_async_idx", BYTE_IDX, 0);
    chk("rst_async_grant", GRANT, 0);
    chk("rst_ready0", REQ0_READY, 0);
    idleCycles(3);
    RESET = 1'b0;
    idleCycles(2);

    // First tie after reset must go to requester 0.
    REQ0_DATA  = 32'hCAFE_0000;
    REQ1_DATA  = 32'h0000_BEEF;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    waitAccept(0);
    waitAccept(1);
    idleCycles(8);
    chk("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nBad);
    $finish;
  end

endmodule

// File: doc/size_convert_sched.md
# size_convert_sched

Two-requester scheduler that shares one word-to-byte size converter between two word sources. It arbitrates round-robin at word boundaries, loads the granted 32- or 16-bit word, and emits it one byte per BIT_RATE_CLK10 cycle, LSB first. When no word is pending it fills the byte stream with an idle symbol. It sits between the PCLK-side buffers and the serializer lane of the PHY transmit path.

## Interface
- SIZE, 8, byte width in bits
- IDLE_SYM, 8'h7C, filler byte driven when no word is in flight
- BIT_RATE_CLK10  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high
- MODE  in  1  word width: 0 = 16-bit (2 bytes), 1 = 32-bit (4 bytes); sampled only at word load
- REQ0_VALID  in  1  requester 0 has a word
- REQ0_DATA  in  4*SIZE  requester 0 word; [2*SIZE-1:0] used in 16-bit mode
- REQ0_READY  out  1  word accepted this cycle (combinational)
- REQ1_VALID, REQ1_DATA, REQ1_READY  same as requester 0
- DATA_OUT  out  SIZE  registered byte stream
- VALID_OUT  out  1  DATA_OUT carries a data byte
- IDLE_BUFFER  out  1  DATA_OUT carries IDLE_SYM
- GRANT  out  1  requester owning the byte on DATA_OUT
- BYTE_IDX  out  2  index of the byte on DATA_OUT within its word

## Operation
- States: EMPTY (no word held) and SEND (word held, BYTE_IDX < NBYTES). NBYTES is 4 when MODE=1 at load, else 2.
- Load opportunity (LOAD_EN): state EMPTY, or state SEND with BYTE_IDX = NBYTES-1. Back-to-back words have no gap.
- Arbitration (only when LOAD_EN):
  - One VALID: that requester wins.
  - Both VALID: the requester not granted last wins.
  - Last-grant pointer updates only on an accepted word.
- REQn_READY = LOAD_EN & winner==n & REQn_VALID. At most one READY is high per cycle.
- Handshake: transfer when VALID & READY are high in the same cycle.
  - Requester holds VALID and DATA stable until READY.
  - Deasserting VALID without READY is legal; the word is simply not taken.
- On transfer, the scheduler latches:
  - the word,
  - NBYTES from MODE,
  - GRANT.
- Byte k is word[(k+1)*SIZE-1 : k*SIZE].
- MODE changes while in SEND have no effect on the current word.
- No transfer at LOAD_EN with the last byte out: go to EMPTY. DATA_OUT = IDLE_SYM, IDLE_BUFFER=1, VALID_OUT=0, BYTE_IDX=0, GRANT holds its last value.
- VALID_OUT and IDLE_BUFFER are always complementary.
- Reset values: DATA_OUT=IDLE_SYM, VALID_OUT=0, IDLE_BUFFER=1, GRANT=0, BYTE_IDX=0, state EMPTY, last-grant pointer=1 (requester 0 wins the first tie). Both READYs are 0 while RESET is high.
- RESET mid-word: the held word is discarded immediately; no partial bytes follow after release.

## Timing
- Latency: handshake in cycle c gives byte 0 on DATA_OUT after the rising edge ending c, then one byte per edge.
- 32-bit word occupies 4 consecutive output cycles; 16-bit word occupies 2.
- Sustained throughput with a requester always valid: 1 byte/clock, zero idle bytes between words.
- READY is combinational from VALID and state; no VALID-to-READY loop is permitted on the requester side.
- Asynchronous RESET assertion forces all registered outputs to reset values without a clock edge.

## Structure
- Shared package size_conv_pkg holds:
  - state enum (EMPTY, SEND),
  - IDLE_SYM default,
  - byte-count constants NB16=2 and NB32=4.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs req[1:0], load_en, accept, and outputs winner and pointer.
- The top level holds the word register, byte counter, output mux and output registers.

## Test plan
- Reset then no VALID for 10 cycles -> DATA_OUT=8'h7C, IDLE_BUFFER=1, VALID_OUT=0, READYs 0 during RESET.
- REQ0 word 32'hDDCCBBAA, MODE=1 -> bytes AA,BB,CC,DD on four consecutive cycles, BYTE_IDX 0..3, GRANT=0, then 7C.
- MODE=0, REQ1 word 32'h1234_5678 -> bytes 78,56 only, GRANT=1. MODE toggled to 1 mid-word -> still 2 bytes.
- Both requesters continuously valid, MODE=1 -> grants alternate 0,1,0,1 and there is no 7C between words.
- REQ0 VALID held 3 cycles while REQ1 word in SEND -> REQ0_READY only on REQ1's last-byte cycle, data unchanged, byte 0 follows immediately.
- RESET asserted after byte 1 of a 32-bit word -> next DATA_OUT=7C, byte 2 never emitted, and the first tie after release goes to requester 0.
